// File: rtl/grf_pkg.sv
// grf_pkg: shared defaults, register-zero constant, register index type and popcount helper
package grf_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO = 0;

    typedef logic [ADDR_W_DEF-1:0] regIdx_t;

    function automatic int popcount(input logic [255:0] v);
        int n = 0;
        for (int i = 0; i < 256; i++) n += int'(v[i]);
        return n;
    endfunction
endpackage

// File: rtl/grf_mp_if.sv
// grf_mp_if: read, write, issue and scoreboard signals of the multi-port register file
interface grf_mp_if import grf_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0] rd_busy;
    logic [NUM_WR-1:0] wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic [NUM_WR*32-1:0] wr_pc;
    logic iss_en;
    logic [ADDR_W-1:0] iss_addr;
    logic [ADDR_W:0] busy_cnt;

    modport master(
        output rd_addr, wr_en, wr_addr, wr_data, wr_pc, iss_en, iss_addr,
        input rd_data, rd_busy, busy_cnt
    );
    modport slave(
        input rd_addr, wr_en, wr_addr, wr_data, wr_pc, iss_en, iss_addr,
        output rd_data, rd_busy, busy_cnt
    );
endinterface

// File: rtl/grf_wr_arb.sv
// grf_wr_arb: resolves the write ports hitting one address; the highest port index wins
module grf_wr_arb import grf_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_WR = 2
) (
    input  logic [NUM_WR-1:0]        wrEn,
    input  logic [NUM_WR*ADDR_W-1:0] wrAddr,
    input  logic [NUM_WR*DATA_W-1:0] wrData,
    input  logic [ADDR_W-1:0]        addr,
    output logic                     hit,
    output logic [DATA_W-1:0]        data
);
    always_comb begin
        hit = 1'b0;
        data = '0;
        for (int j = 0; j < NUM_WR; j++)
            if (wrEn[j] && wrAddr[j*ADDR_W +: ADDR_W] == addr && addr != ADDR_W'(REG_ZERO)) begin
                hit = 1'b1;
                data = wrData[j*DATA_W +: DATA_W];
            end
    end
endmodule

// File: rtl/grf_mp.sv
// grf_mp: multi-port register file with write-through bypass, pending scoreboard and optional GRF_TRACE_EN write trace
module grf_mp import grf_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
) (
    input logic clk,
    input logic reset,
    grf_mp_if.slave bus
);
    localparam int NREG = 2**ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] regWd [NREG];
    logic [NREG-1:0] regHit, pend, pendNext;

    for (genvar r = 0; r < NREG; r++) begin : g_reg
        grf_wr_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR)) arb (
            .wrEn(bus.wr_en), .wrAddr(bus.wr_addr), .wrData(bus.wr_data),
            .addr(ADDR_W'(r)), .hit(regHit[r]), .data(regWd[r])
        );
    end

    // regs[0] is never written, so address 0 reads zero without a special case
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic hit;
        logic [DATA_W-1:0] wd;
        assign a = bus.rd_addr[k*ADDR_W +: ADDR_W];
        grf_wr_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR)) arb (
            .wrEn(bus.wr_en), .wrAddr(bus.wr_addr), .wrData(bus.wr_data),
            .addr(a), .hit(hit), .data(wd)
        );
        assign bus.rd_data[k*DATA_W +: DATA_W] = hit ? wd : regs[a];
        assign bus.rd_busy[k] = pend[a] && !hit;
    end

    // issue wins over a same-cycle writeback to the same register
    always_comb begin
        pendNext = '0;
        for (int r = 1; r < NREG; r++)
            pendNext[r] = (bus.iss_en && bus.iss_addr == ADDR_W'(r)) || (pend[r] && !regHit[r]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) regs[r] <= '0;
            pend <= '0;
            bus.busy_cnt <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) if (regHit[r]) regs[r] <= regWd[r];
            pend <= pendNext;
            bus.busy_cnt <= (ADDR_W+1)'(popcount(256'(pendNext)));
        end
    end

`ifdef GRF_TRACE_EN
    always @(posedge clk) begin
        if (reset)
            for (int j = 0; j < NUM_WR; j++) begin
                automatic logic [ADDR_W-1:0] a = bus.wr_addr[j*ADDR_W +: ADDR_W];
                automatic logic eff = bus.wr_en[j] && a != ADDR_W'(REG_ZERO);
                for (int i = j + 1; i < NUM_WR; i++)
                    if (bus.wr_en[i] && bus.wr_addr[i*ADDR_W +: ADDR_W] == a) eff = 1'b0;
                if (eff) $display("@%h: $%d <= %h", bus.wr_pc[j*32 +: 32], a, bus.wr_data[j*DATA_W +: DATA_W]);
            end
    end
`endif
endmodule
